// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - Program counter generator with BOOT/RUN/HALT control; optional PC_MISALIGN_CHECK_EN traps misaligned redirects
module pc_gen #(
    parameter int unsigned            XLEN         = 32,
    parameter logic [XLEN-1:0]        RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]        TRAP_VECTOR  = XLEN'('h100),
    parameter int unsigned            INC          = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap,
    input  logic            mret,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc_out,
    output logic            misaligned
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] epc_nxt;
    logic            mis_nxt;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_out;
        epc_nxt   = epc_out;
        mis_nxt   = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (trap) begin
                    pc_nxt  = TRAP_VECTOR;
                    epc_nxt = pc_out;
                end else if (halt_req) begin
                    state_nxt = HALT;
                end else if (mret) begin
                    pc_nxt = epc_out;
                end else if (redirect_valid) begin
`ifdef PC_MISALIGN_CHECK_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        pc_nxt  = TRAP_VECTOR;
                        epc_nxt = redirect_pc;
                        mis_nxt = 1'b1;
                    end else begin
                        pc_nxt = redirect_pc;
                    end
`else
                    pc_nxt = redirect_pc & ALIGN_MASK;
`endif
                end else if (!stall) begin
                    // Natural wrap modulo 2^XLEN from the fixed-width add
                    pc_nxt = pc_out + INC_W;
                end
            end
            HALT: begin
                if (trap) begin
                    pc_nxt    = TRAP_VECTOR;
                    epc_nxt   = pc_out;
                    state_nxt = RUN;
                end else if (resume) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = BOOT;
                pc_nxt    = RESET_VECTOR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= BOOT;
            pc_out  <= RESET_VECTOR;
            epc_out <= '0;
        end else begin
            state   <= state_nxt;
            pc_out  <= pc_nxt;
            epc_out <= epc_nxt;
        end
    end

`ifdef PC_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misaligned <= 1'b0;
        end else begin
            misaligned <= mis_nxt;
        end
    end
`else
    logic unused_mis;
    assign unused_mis = mis_nxt;
    assign misaligned = 1'b0;
`endif

    assign pc_valid = (state == RUN);

endmodule
